// File: rtl/life_pkg.sv
// Shared types and constants for the Game of Life engine: rule masks, FSM encoding,
// the latched rule bundle and the flat cell index helper.
package life_pkg;

    localparam logic [8:0] RULE_CONWAY_B   = 9'b000001000;
    localparam logic [8:0] RULE_CONWAY_S   = 9'b000001100;
    localparam logic [8:0] RULE_HIGHLIFE_B = 9'b001001000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        STAMP = 2'd2,
        COUNT = 2'd3
    } life_state_e;

    typedef struct packed {
        logic       wrap;
        logic [8:0] birth;
        logic [8:0] survive;
    } life_rule_t;

    function automatic int idx(input int y, input int x, input int max_x);
        return y * max_x + x;
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Next generation of one grid row from its north/centre/south rows, plus the row popcount.
// With count_only set the centre row passes through so the popcount tallies it unchanged.
module life_row_next
    import life_pkg::*;
#(
    parameter  int MAX_X = 40,
    localparam int PCW   = $clog2(MAX_X + 1),
    localparam int XIW   = $clog2(MAX_X)
) (
    input  logic [MAX_X-1:0] north,
    input  logic [MAX_X-1:0] centre,
    input  logic [MAX_X-1:0] south,
    input  life_rule_t       rule,
    input  logic             count_only,
    output logic [MAX_X-1:0] new_row,
    output logic [PCW-1:0]   pop
);

    for (genvar x = 0; x < MAX_X; x++) begin : g_cell
        localparam int XL = (x == 0) ? MAX_X - 1 : x - 1;
        localparam int XR = (x == MAX_X - 1) ? 0 : x + 1;
        logic       lv, rv;
        logic [3:0] n;

        // Columns off either edge only exist on the torus.
        assign lv = rule.wrap || (x != 0);
        assign rv = rule.wrap || (x != MAX_X - 1);
        assign n  = 4'(north[XL] & lv)  + 4'(north[x])  + 4'(north[XR] & rv) +
                    4'(centre[XL] & lv)                 + 4'(centre[XR] & rv) +
                    4'(south[XL] & lv)  + 4'(south[x])  + 4'(south[XR] & rv);
        assign new_row[x] = count_only ? centre[x]
                          : (centre[x] ? rule.survive[n] : rule.birth[n]);
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < MAX_X; i++) pop = pop + PCW'(new_row[XIW'(i)]);
    end

endmodule

// File: rtl/life_engine.sv
// Row-serial Game of Life engine: one grid row per cycle for generations and population
// counts, single-cycle wrapped pattern stamp, single-cycle clear, busy/done handshake.
module life_engine
    import life_pkg::*;
#(
    parameter  int MAX_X = 40,
    parameter  int MAX_Y = 30,
    parameter  int PAT_W = 8,
    parameter  int GEN_W = 16,
    localparam int CELLS = MAX_X * MAX_Y,
    localparam int POP_W = $clog2(CELLS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step,
    input  logic                   draw,
    input  logic                   clear,
    input  logic                   freeze,
    input  logic                   wrap,
    input  logic [8:0]             birth_mask,
    input  logic [8:0]             survive_mask,
    input  logic [7:0]             cursor_x,
    input  logic [7:0]             cursor_y,
    input  logic [PAT_W*PAT_W-1:0] pat,
    output logic [CELLS-1:0]       state,
    output logic                   busy,
    output logic                   done,
    output logic [POP_W-1:0]       population,
    output logic [GEN_W-1:0]       generation
);

    localparam int RW        = $clog2(MAX_Y);
    localparam int PCW       = $clog2(MAX_X + 1);
    localparam int CIW       = $clog2(CELLS);
    localparam int PIW       = $clog2(PAT_W);
    localparam int LAST_BASE = (MAX_Y - 1) * MAX_X;

    life_state_e                       st, st_nx;
    logic [RW-1:0]                     r;
    logic                              last_row, fin_evt;
    logic [1:0]                        vld_pipe;
    logic [CIW-1:0]                    row_base, south_base;
    logic [MAX_X-1:0]                  prev_orig, row0_orig, north, centre, south, new_row;
    logic [PCW-1:0]                    row_pop;
    logic [POP_W-1:0]                  pop_acc, pop_sum;
    life_rule_t                        rule_l;
    logic [7:0]                        cur_x, cur_y;
    logic [PAT_W-1:0][PAT_W-1:0]       pat_l;
    logic [CELLS-1:0]                  stamped;

    assign last_row = (r == RW'(MAX_Y - 1));
    assign pop_sum  = pop_acc + POP_W'(row_pop);
    // done trails the completing edge by one cycle.
    assign done     = vld_pipe[1];

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE: begin
                if (!clear && draw)                 st_nx = STAMP;
                else if (!clear && step && !freeze) st_nx = STEP;
            end
            STEP:    if (last_row) st_nx = IDLE;
            STAMP:   st_nx = COUNT;
            COUNT:   if (last_row) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (st != IDLE);
        fin_evt = 1'b0;
        case (st)
            IDLE:        fin_evt = clear;
            STEP, COUNT: fin_evt = last_row;
            default:     fin_evt = 1'b0;
        endcase
    end

    // Rows above r are already rewritten, so north comes from the saved pre-update copy.
    always_comb begin
        row_base   = CIW'(int'(r) * MAX_X);
        south_base = last_row ? '0 : CIW'((int'(r) + 1) * MAX_X);
        centre     = state[row_base +: MAX_X];
        north      = (r == '0) ? (rule_l.wrap ? state[LAST_BASE +: MAX_X] : '0) : prev_orig;
        south      = last_row ? (rule_l.wrap ? row0_orig : '0) : state[south_base +: MAX_X];
    end

    life_row_next #(.MAX_X(MAX_X)) u_row (
        .north      (north),
        .centre     (centre),
        .south      (south),
        .rule       (rule_l),
        .count_only (st == COUNT),
        .new_row    (new_row),
        .pop        (row_pop)
    );

    always_comb begin
        int yy, xx;
        yy      = 0;
        xx      = 0;
        stamped = state;
        for (int pr = 0; pr < PAT_W; pr++) begin
            for (int pc = 0; pc < PAT_W; pc++) begin
                yy = (int'(cur_y) + pr) % MAX_Y;
                xx = (int'(cur_x) + pc) % MAX_X;
                if (pat_l[PIW'(pr)][PIW'(pc)]) stamped[CIW'(idx(yy, xx, MAX_X))] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= '0;
            population <= '0;
            generation <= '0;
            vld_pipe   <= '0;
            r          <= '0;
            pop_acc    <= '0;
            prev_orig  <= '0;
            row0_orig  <= '0;
            rule_l     <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            pat_l      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], fin_evt};
            case (st)
                IDLE: begin
                    r       <= '0;
                    pop_acc <= '0;
                    if (clear) begin
                        state      <= '0;
                        population <= '0;
                        generation <= '0;
                    end else if (draw) begin
                        cur_x <= cursor_x;
                        cur_y <= cursor_y;
                        pat_l <= pat;
                    end else if (step && !freeze) begin
                        rule_l <= '{wrap: wrap, birth: birth_mask, survive: survive_mask};
                    end
                end
                STEP: begin
                    state[row_base +: MAX_X] <= new_row;
                    prev_orig <= centre;
                    if (r == '0) row0_orig <= centre;
                    pop_acc <= pop_sum;
                    r       <= r + RW'(1);
                    if (last_row) begin
                        population <= pop_sum;
                        generation <= generation + GEN_W'(1);
                    end
                end
                STAMP: state <= stamped;
                COUNT: begin
                    pop_acc <= pop_sum;
                    r       <= r + RW'(1);
                    if (last_row) population <= pop_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench for life_engine: each accepted command queues the expected grid,
// population, generation and done cycle; a monitor checks them on every done pulse.
module tb_life_engine;
    import life_pkg::*;

    localparam int MX    = 40;
    localparam int MY    = 30;
    localparam int PW    = 8;
    localparam int GW    = 16;
    localparam int CELLS = MX * MY;
    localparam int POPW  = $clog2(CELLS + 1);

    typedef logic [CELLS-1:0] grid_t;
    typedef struct {
        grid_t grid;
        int    pop;
        int    gen;
        int    cyc;
        int    id;
    } exp_t;

    logic             clk = 1'b0, rst = 1'b1;
    logic             step = 1'b0, draw = 1'b0, clear = 1'b0, freeze = 1'b0, wrap = 1'b1;
    logic [8:0]       birth_mask = RULE_CONWAY_B, survive_mask = RULE_CONWAY_S;
    logic [7:0]       cursor_x = '0, cursor_y = '0;
    logic [PW*PW-1:0] pat = '0;
    grid_t            state;
    logic             busy, done;
    logic [POPW-1:0]  population;
    logic [GW-1:0]    generation;

    life_engine #(.MAX_X(MX), .MAX_Y(MY), .PAT_W(PW), .GEN_W(GW)) dut (
        .clk(clk), .rst(rst), .step(step), .draw(draw), .clear(clear), .freeze(freeze),
        .wrap(wrap), .birth_mask(birth_mask), .survive_mask(survive_mask),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .pat(pat), .state(state), .busy(busy),
        .done(done), .population(population), .generation(generation)
    );

    always #5 clk = ~clk;

    int    cyc = 0, n_chk = 0, n_fail = 0, op_id = 0, mgen = 0;
    exp_t  q[$];
    exp_t  me;
    grid_t mgrid = '0;
    grid_t hg;

    localparam logic [63:0] PAT_BLINK = 64'h0000_0000_0000_0007;
    localparam logic [63:0] PAT_SIX   = 64'h0000_0000_0001_0507;
    localparam logic [63:0] PAT_BLOCK = 64'h0000_0000_0000_0303;
    localparam logic [63:0] PAT_GLIDE = 64'h0000_0000_0007_0402;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] ci(input int y, input int x);
        return 11'(y * MX + x);
    endfunction

    function automatic grid_t m_stamp(input grid_t g, input logic [63:0] p, input int cx, input int cy);
        for (int pr = 0; pr < PW; pr++)
            for (int pc = 0; pc < PW; pc++)
                if (p[6'(pr * PW + pc)]) g[ci((cy + pr) % MY, (cx + pc) % MX)] = 1'b1;
        return g;
    endfunction

    // Reference generation on a 2-D view of the grid.
    function automatic grid_t m_step(input grid_t g, input bit w, input logic [8:0] b, input logic [8:0] s);
        grid_t o;
        int    n, yy, xx;
        o = '0;
        for (int y = 0; y < MY; y++) begin
            for (int x = 0; x < MX; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dy == 0 && dx == 0) continue;
                        yy = y + dy;
                        xx = x + dx;
                        if (w) begin
                            yy = (yy + MY) % MY;
                            xx = (xx + MX) % MX;
                        end
                        if (yy >= 0 && yy < MY && xx >= 0 && xx < MX) n += int'(g[ci(yy, xx)]);
                    end
                end
                o[ci(y, x)] = g[ci(y, x)] ? s[4'(n)] : b[4'(n)];
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_grid(input string nm, input grid_t act, input grid_t exp);
        int first, nd;
        first = -1;
        nd    = 0;
        n_chk++;
        if (act !== exp) begin
            for (int i = 0; i < CELLS; i++)
                if (act[11'(i)] !== exp[11'(i)]) begin
                    nd++;
                    if (first < 0) first = i;
                end
            n_fail++;
            $display("FAIL %s: %0d cells differ, first (y=%0d,x=%0d) got %0b expected %0b",
                     nm, nd, first / MX, first % MX, act[11'(first)], exp[11'(first)]);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                me = q.pop_front();
                chk_grid($sformatf("grid op%0d", me.id), state, me.grid);
                chk($sformatf("pop op%0d", me.id), int'(population), me.pop);
                chk($sformatf("gen op%0d", me.id), int'(generation), me.gen);
                chk($sformatf("done_cycle op%0d", me.id), cyc, me.cyc);
            end
        end
    end

    task automatic push(input int lat);
        exp_t e;
        e.grid = mgrid;
        e.pop  = $countones(mgrid);
        e.gen  = mgen;
        e.cyc  = cyc + 1 + lat;
        e.id   = op_id;
        op_id  = op_id + 1;
        q.push_back(e);
    endtask

    task automatic wait_q();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got %0d pending ops expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        mgrid = '0;
        mgen  = 0;
        push(1);
        @(posedge clk);
        #1 clear = 1'b0;
        wait_q();
    endtask

    task automatic do_draw(input logic [63:0] p, input int x, input int y);
        pat      = p;
        cursor_x = 8'(x);
        cursor_y = 8'(y);
        draw     = 1'b1;
        mgrid    = m_stamp(mgrid, p, x, y);
        push(MY + 2);
        @(posedge clk);
        #1 draw = 1'b0;
        wait_q();
    endtask

    task automatic do_step();
        step  = 1'b1;
        mgrid = m_step(mgrid, wrap, birth_mask, survive_mask);
        mgen  = (mgen + 1) % (1 << GW);
        push(MY + 1);
        @(posedge clk);
        #1 step = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_grid("reset_state", state, '0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pop", int'(population), 0);
        chk("reset_gen", int'(generation), 0);
        rst = 1'b0;
        @(negedge clk);

        // Blinker: horizontal stamp, vertical after one step.
        do_draw(PAT_BLINK, 4, 5);
        hg = '0;
        hg[ci(5, 4)] = 1'b1; hg[ci(5, 5)] = 1'b1; hg[ci(5, 6)] = 1'b1;
        chk_grid("blinker_drawn", state, hg);
        do_step();
        wait_q();
        hg = '0;
        hg[ci(4, 5)] = 1'b1; hg[ci(5, 5)] = 1'b1; hg[ci(6, 5)] = 1'b1;
        chk_grid("blinker_step", state, hg);

        // clear outranks draw and step when all arrive together.
        pat   = PAT_SIX;
        clear = 1'b1; draw = 1'b1; step = 1'b1;
        mgrid = '0;
        mgen  = 0;
        push(1);
        @(posedge clk);
        #1 clear = 1'b0; draw = 1'b0; step = 1'b0;
        @(negedge clk);
        chk("prio_not_busy", int'(busy), 0);
        wait_q();
        repeat (5) @(negedge clk);

        // Six-neighbour dead cell: born under HighLife, stays dead under Conway.
        do_draw(PAT_SIX, 10, 10);
        birth_mask = RULE_HIGHLIFE_B;
        do_step();
        wait_q();
        chk("highlife_birth", int'(state[ci(11, 11)]), 1);
        birth_mask = RULE_CONWAY_B;
        do_clear();
        do_draw(PAT_SIX, 10, 10);
        do_step();
        wait_q();
        chk("conway_no_birth", int'(state[ci(11, 11)]), 0);

        // Dead border: corner block is stable; stamp at the last cell wraps and then dies.
        do_clear();
        wrap = 1'b0;
        do_draw(PAT_BLOCK, 38, 28);
        hg = '0;
        hg[ci(28, 38)] = 1'b1; hg[ci(28, 39)] = 1'b1; hg[ci(29, 38)] = 1'b1; hg[ci(29, 39)] = 1'b1;
        repeat (2) begin
            do_step();
            wait_q();
            chk_grid("border_block", state, hg);
        end
        do_clear();
        do_draw(PAT_BLOCK, 39, 29);
        hg = '0;
        hg[ci(29, 39)] = 1'b1; hg[ci(29, 0)] = 1'b1; hg[ci(0, 39)] = 1'b1; hg[ci(0, 0)] = 1'b1;
        chk_grid("stamp_wrap", state, hg);
        do_step();
        wait_q();
        chk("corner_pop", int'(population), 0);
        wrap = 1'b1;

        // Glider on the torus: four generations shift it by (+1,+1) across both seams.
        do_clear();
        do_draw(PAT_GLIDE, 37, 27);
        repeat (4) begin
            do_step();
            wait_q();
        end
        hg = '0;
        hg[ci(28, 39)] = 1'b1; hg[ci(29, 0)] = 1'b1; hg[ci(0, 38)] = 1'b1;
        hg[ci(0, 39)] = 1'b1;  hg[ci(0, 0)] = 1'b1;
        chk_grid("glider_shift", state, hg);
        chk("glider_pop", int'(population), 5);
        chk("glider_gen", int'(generation), 4);

        // freeze blocks step entirely.
        freeze = 1'b1;
        step   = 1'b1;
        repeat (3) @(posedge clk);
        #1 step = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
        chk("freeze_not_busy", int'(busy), 0);
        repeat (40) @(negedge clk);
        chk_grid("freeze_grid", state, mgrid);
        chk("freeze_gen", int'(generation), mgen);

        // A second step while busy is dropped.
        do_step();
        repeat (4) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_q();
        repeat (40) @(negedge clk);
        chk("busy_step_gen", int'(generation), mgen);

        // Reset lands while row 10 of a step is being processed.
        step = 1'b1;
        @(posedge clk);
        #1 step = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midstep_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_grid("rst_state", state, '0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pop", int'(population), 0);
        chk("rst_gen", int'(generation), 0);
        rst   = 1'b0;
        mgrid = '0;
        mgen  = 0;
        repeat (40) @(negedge clk);

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
